// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-granular round-robin arbiter feeding one valid/ready sink.
// Define STREAM_ARB_OUT_REG_EN to register the master side through a 2-entry skid buffer.
module stream_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_data_i,
  input  logic [N_REQ-1:0]            s_valid_i,
  input  logic [N_REQ-1:0]            s_last_i,
  output logic [N_REQ-1:0]            s_ready_o,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic [ID_WIDTH-1:0]         m_id_o,
  output logic                        m_last_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic                        busy_o
);
  // state | meaning
  // IDLE  | no packet owns the sink; winner picked round-robin from rr_ptr every cycle
  // LOCK  | lock_id owns the sink until its last beat is accepted
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   lock_id;
  logic [ID_WIDTH-1:0]   win_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  win_found;
  logic                  grant_valid;
  logic                  grant_last;
  logic                  arb_ready;
  logic                  arb_fire;
  logic [DATA_WIDTH-1:0] grant_data;

  function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] idx);
    return ID_WIDTH'((int'(idx) + 1) % N_REQ);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_WIDTH'((int'(rr_ptr) + i) % N_REQ);
      if (!win_found && s_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant_id    = (state == LOCK) ? lock_id : win_idx;
  assign grant_valid = (state == LOCK) ? s_valid_i[lock_id] : win_found;
  assign grant_last  = s_last_i[grant_id];
  assign arb_fire    = grant_valid && arb_ready;

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id == ID_WIDTH'(k)) grant_data = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The lock owner stays connected through gaps; in IDLE only a present winner is readied.
  always_comb begin
    s_ready_o = '0;
    if (state == LOCK || win_found) s_ready_o[grant_id] = arb_ready;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            if (arb_ready && grant_last) begin
              rr_ptr <= next_idx(win_idx);
            end else begin
              // a stalled single-beat packet also locks so the grant cannot move under it
              state   <= LOCK;
              lock_id <= win_idx;
              busy_o  <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (arb_fire && grant_last) begin
            state  <= IDLE;
            rr_ptr <= next_idx(lock_id);
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef STREAM_ARB_OUT_REG_EN
  localparam int BEAT_W = ID_WIDTH + 1 + DATA_WIDTH;

  logic [BEAT_W-1:0] skid_q [2];
  logic [1:0]        skid_cnt;
  logic              skid_wp;
  logic              skid_rp;
  logic              skid_push;
  logic              skid_pop;

  assign arb_ready = (skid_cnt != 2'd2);
  assign skid_push = arb_fire;
  assign skid_pop  = m_valid_o && m_ready_i;
  assign m_valid_o = (skid_cnt != 2'd0);
  assign {m_id_o, m_last_o, m_data_o} = skid_q[skid_rp];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      skid_cnt <= 2'd0;
      skid_wp  <= 1'b0;
      skid_rp  <= 1'b0;
    end else begin
      skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
      if (skid_push) skid_wp <= ~skid_wp;
      if (skid_pop)  skid_rp <= ~skid_rp;
    end
  end

  always_ff @(posedge ACLK) begin
    if (skid_push) skid_q[skid_wp] <= {grant_id, grant_last, grant_data};
  end
`else
  assign arb_ready = m_ready_i;
  assign m_valid_o = grant_valid;
  assign m_data_o  = grant_data;
  assign m_id_o    = grant_id;
  assign m_last_o  = grant_last;
`endif

endmodule
